// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-port and memory-port bundle for the instruction cache
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    // Bench/datapath+memory side
    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    // Cache side
    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, one word per block
// Optional hit/miss counters enabled by defining ICACHE_STATS_EN.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    icache_if.slave     cif
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state, next_state;
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [31:0]       data [SETS];
    logic [31:0]       maddr, next_maddr;

    logic [IDX_W-1:0]  idx, fidx;
    logic [TAG_W-1:0]  rtag, ftag;
    logic              hit, fill, miss_start;

    assign idx  = cif.imemaddr[IDX_W+1:2];
    assign rtag = cif.imemaddr[31:IDX_W+2];
    assign fidx = maddr[IDX_W+1:2];
    assign ftag = maddr[31:IDX_W+2];

    assign hit  = cif.imemREN & valid[idx] & (tags[idx] == rtag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            maddr <= 32'h0;
        end else begin
            state <= next_state;
            maddr <= next_maddr;
        end
    end

    always_comb begin
        next_state   = state;
        next_maddr   = maddr;
        cif.ihit     = 1'b0;
        cif.imemload = 32'h0;
        cif.iREN     = 1'b0;
        cif.iaddr    = 32'h0;
        fill         = 1'b0;
        miss_start   = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    cif.ihit     = 1'b1;
                    cif.imemload = data[idx];
                end else if (cif.imemREN) begin
                    miss_start = 1'b1;
                    next_state = FETCH;
                    next_maddr = {cif.imemaddr[31:2], 2'b00};
                end
            end
            FETCH: begin
                cif.iREN  = 1'b1;
                cif.iaddr = maddr;
                if (!cif.iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (fill) begin
            valid[fidx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are ignored while the frame's valid bit is clear.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[fidx] <= ftag;
            data[fidx] <= cif.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (cif.ihit)  hit_count  <= hit_count + 32'd1;
            if (miss_start) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;
    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   failures = 0;

    icache_if cif();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    icache dut (.CLK(CLK), .nRST(nRST), .cif(cif),
                .hit_count(hit_count), .miss_count(miss_count));
`else
    icache dut (.CLK(CLK), .nRST(nRST), .cif(cif));
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Miss, nwait busy cycles, fill, then the hit cycle that follows the fill.
    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] word, input int nwait);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        @(negedge CLK);
        cif.imemREN = 1'b1; cif.imemaddr = addr; cif.iwait = 1'b1;
        #1;
        chk("miss_detect_ihit", cif.ihit, 0);
        chk("miss_detect_iren", cif.iREN, 0);
        chk("miss_detect_iaddr", cif.iaddr, 0);
        for (int i = 0; i < nwait; i++) begin
            @(negedge CLK); #1;
            chk("fetch_iren", cif.iREN, 1);
            chk("fetch_iaddr", cif.iaddr, waddr);
            chk("fetch_ihit", cif.ihit, 0);
        end
        @(negedge CLK);
        cif.iwait = 1'b0; cif.iload = word;
        #1;
        chk("fill_iren", cif.iREN, 1);
        chk("fill_iaddr", cif.iaddr, waddr);
        @(negedge CLK);
        cif.iwait = 1'b1; cif.iload = 32'hDEAD_BEEF;
        #1;
        chk("after_fill_ihit", cif.ihit, 1);
        chk("after_fill_data", cif.imemload, word);
        chk("after_fill_iren", cif.iREN, 0);
    endtask

    task automatic expect_hit(input logic [31:0] addr, input logic [31:0] word);
        @(negedge CLK);
        cif.imemREN = 1'b1; cif.imemaddr = addr;
        #1;
        chk("hit_ihit", cif.ihit, 1);
        chk("hit_data", cif.imemload, word);
        chk("hit_iren", cif.iREN, 0);
    endtask

    initial begin
        nRST = 1'b0;
        cif.imemREN = 1'b0; cif.imemaddr = 32'h0;
        cif.iwait = 1'b1;   cif.iload = 32'h0;
        #2;
        chk("rst_ihit", cif.ihit, 0);
        chk("rst_iren", cif.iREN, 0);
        chk("rst_iaddr", cif.iaddr, 0);
        chk("rst_imemload", cif.imemload, 0);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
`endif
        @(negedge CLK); nRST = 1'b1;

        // Cold miss at 0x0 with two busy cycles
        fetch_miss(32'h0000_0000, 32'h2001_0005, 2);

        // Fill 0x04..0x3C, then hit stream
        for (int a = 4; a < 64; a += 4)
            fetch_miss(32'(a), 32'hA000_0000 + 32'(a), (a / 4) % 3);
        for (int a = 4; a < 64; a += 4)
            expect_hit(32'(a), 32'hA000_0000 + 32'(a));
        expect_hit(32'h0000_0002, 32'h2001_0005);

        // Conflict on frame 0
        fetch_miss(32'h0000_0040, 32'hBBBB_0040, 1);
        fetch_miss(32'h0000_0000, 32'h2001_0005, 0);
        expect_hit(32'h0000_0004, 32'hA000_0004);

        // No request with an uncached address
        @(negedge CLK);
        cif.imemREN = 1'b0; cif.imemaddr = 32'h0000_1000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("noreq_ihit", cif.ihit, 0);
            chk("noreq_iren", cif.iREN, 0);
            chk("noreq_imemload", cif.imemload, 0);
            @(negedge CLK);
        end

        // Reset during a pending fill
        cif.imemREN = 1'b1; cif.imemaddr = 32'h0000_0080; cif.iwait = 1'b1;
        @(negedge CLK); #1;
        chk("pre_rst_iren", cif.iREN, 1);
        #2 nRST = 1'b0;
        #1;
        chk("async_rst_iren", cif.iREN, 0);
        chk("async_rst_iaddr", cif.iaddr, 0);
        cif.imemREN = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        fetch_miss(32'h0000_0000, 32'h2001_0005, 1);
        fetch_miss(32'h0000_0080, 32'hCCCC_0080, 0);
        fetch_miss(32'h0000_0004, 32'hA000_0004, 0);

`ifdef ICACHE_STATS_EN
        // Counters after a fresh reset: 3 cold misses then 5 hits
        @(negedge CLK); nRST = 1'b0; cif.imemREN = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        fetch_miss(32'h0000_0100, 32'h1111_0100, 1);
        fetch_miss(32'h0000_0104, 32'h1111_0104, 0);
        fetch_miss(32'h0000_0108, 32'h1111_0108, 2);
        expect_hit(32'h0000_0100, 32'h1111_0100);
        expect_hit(32'h0000_0104, 32'h1111_0104);
        expect_hit(32'h0000_0108, 32'h1111_0108);
        expect_hit(32'h0000_0100, 32'h1111_0100);
        expect_hit(32'h0000_0104, 32'h1111_0104);
        @(negedge CLK); cif.imemREN = 1'b0;
        #1;
        chk("stats_miss_count", miss_count, 3);
        chk("stats_hit_count", hit_count, 8);
`endif

        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
